// File: rtl/register_read_ctrl_if.sv
// Read request / read data handshake bundle for register_read_ctrl.
// master: requester and consumer side; slave: the read controller.
interface register_read_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] bus_data_out;
  logic                  bus_out_valid;
  logic                  bus_ack;

  modport master (
    output rd_req,
    output rd_address,
    input  rd_ready,
    input  bus_data_out,
    input  bus_out_valid,
    output bus_ack
  );

  modport slave (
    input  rd_req,
    input  rd_address,
    output rd_ready,
    output bus_data_out,
    output bus_out_valid,
    input  bus_ack
  );
endinterface

// File: rtl/register_read_ctrl.sv
// Single-register read port for register_file, with same-cycle write forwarding.
// Ports: clk, clr (sync high), bus (read handshake), regs_in, wr_* snoop.
module register_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           clr,
  register_read_ctrl_if.slave            bus,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_in,
  input  logic                           wr_enable,
  input  logic [ADDR_WIDTH-1:0]          wr_address,
  input  logic [DATA_WIDTH-1:0]          bus_data_in
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  logic [DATA_WIDTH-1:0] regs_arr [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  fwd_hit;
  logic                  ready;
  logic                  accept;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_unpack
    assign regs_arr[i] = regs_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign ready = !clr &&
                 ((state_q == IDLE) ||
                  (state_q == HOLD && bus.bus_ack));
  assign accept = bus.rd_req && ready;

  // register_file commits on the same edge we sample, so
  // regs_in is stale for a write to the captured address.
  assign fwd_hit = wr_enable && (wr_address == addr_q);
  assign rd_data = fwd_hit ? bus_data_in : regs_arr[addr_q];

  assign bus.rd_ready      = ready;
  assign bus.bus_data_out  = data_q;
  assign bus.bus_out_valid = valid_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.rd_address;
            state_q <= READ;
          end
        end
        READ: begin
          data_q  <= rd_data;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (bus.bus_ack) begin
            valid_q <= 1'b0;
            if (accept) begin
              addr_q  <= bus.rd_address;
              state_q <= READ;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_read_ctrl.sv
// Bench for register_read_ctrl: directed reads with a data scoreboard.
// Monitor pops expected data on each valid&&ack transfer.
module tb_register_read_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic [NR*DW-1:0] regs_in;
  logic          wr_enable;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] bus_data_in;
  logic [DW-1:0] regs [NR];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];

  register_read_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_read_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .bus        (bus),
    .regs_in    (regs_in),
    .wr_enable  (wr_enable),
    .wr_address (wr_address),
    .bus_data_in(bus_data_in)
  );

  always #5 clk = ~clk;

  always_comb begin
    regs_in = '0;
    for (int i = 0; i < NR; i++)
      regs_in[i*DW +: DW] = regs[i];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a transfer happens on the next edge.
  always @(negedge clk) begin
    if (!clr && bus.bus_out_valid && bus.bus_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0d want none",
                 bus.bus_data_out);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.bus_data_out !== e) begin
          errors++;
          $display("FAIL sb_data: got %0d want %0d",
                   bus.bus_data_out, e);
        end
      end
    end
  end

  task automatic read_one(input logic [AW-1:0] a,
                          input logic [AW-1:0] wa,
                          input logic [DW-1:0] exp);
    bus.bus_ack = 1'b0;
    bus.rd_req = 1'b1;
    bus.rd_address = a;
    exp_q.push_back(exp);
    tick;
    bus.rd_req = 1'b0;
    wr_enable = 1'b1;
    wr_address = wa;
    bus_data_in = 32'd26;
    tick;
    wr_enable = 1'b0;
    check("hold_valid", {31'd0, bus.bus_out_valid}, 1);
    bus.bus_ack = 1'b1;
    tick;
    check("ack_drop", {31'd0, bus.bus_out_valid}, 0);
    bus.bus_ack = 1'b0;
  endtask

  initial begin
    logic [6:0] vpat;
    for (int i = 0; i < NR; i++) regs[i] = 32'h100 + i;
    regs[0] = 32'd16;
    regs[1] = 32'd18;
    regs[3] = 32'd69;
    clr = 1'b1;
    wr_enable = 1'b0;
    wr_address = '0;
    bus_data_in = '0;
    bus.rd_req = 1'b0;
    bus.rd_address = '0;
    bus.bus_ack = 1'b0;
    tick;
    tick;
    clr = 1'b0;
    #1;
    check("rst_valid", {31'd0, bus.bus_out_valid}, 0);
    check("rst_data", bus.bus_data_out, 0);
    check("rst_ready", {31'd0, bus.rd_ready}, 1);

    // Reset mid-HOLD: held R3 is dropped, not transferred.
    bus.rd_req = 1'b1;
    bus.rd_address = 4'd3;
    tick;
    bus.rd_req = 1'b0;
    tick;
    check("pre_clr_valid", {31'd0, bus.bus_out_valid}, 1);
    check("pre_clr_data", bus.bus_data_out, 69);
    clr = 1'b1;
    bus.bus_ack = 1'b1;
    #1;
    check("clr_ready", {31'd0, bus.rd_ready}, 0);
    tick;
    bus.bus_ack = 1'b0;
    check("clr_valid", {31'd0, bus.bus_out_valid}, 0);
    check("clr_data", bus.bus_data_out, 0);
    clr = 1'b0;
    #1;
    check("post_clr_ready", {31'd0, bus.rd_ready}, 1);

    // Basic read with latency check.
    bus.bus_ack = 1'b1;
    bus.rd_req = 1'b1;
    bus.rd_address = 4'd1;
    exp_q.push_back(32'd18);
    tick;
    bus.rd_req = 1'b0;
    check("read_valid0", {31'd0, bus.bus_out_valid}, 0);
    check("read_ready0", {31'd0, bus.rd_ready}, 0);
    tick;
    check("basic_valid", {31'd0, bus.bus_out_valid}, 1);
    check("basic_data", bus.bus_data_out, 18);
    tick;
    check("basic_drop", {31'd0, bus.bus_out_valid}, 0);
    bus.bus_ack = 1'b0;

    // Forwarding hit, then non-matching write.
    read_one(4'd0, 4'd0, 32'd26);
    read_one(4'd0, 4'd2, 32'd16);

    // Backpressure and snapshot.
    bus.rd_req = 1'b1;
    bus.rd_address = 4'd3;
    exp_q.push_back(32'd69);
    tick;
    bus.rd_address = 4'd0;
    check("bp_ready_read", {31'd0, bus.rd_ready}, 0);
    tick;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        wr_enable = 1'b1;
        wr_address = 4'd3;
        bus_data_in = 32'd100;
      end
      tick;
      if (i == 0) begin
        wr_enable = 1'b0;
        regs[3] = 32'd100;
      end
      check("bp_valid", {31'd0, bus.bus_out_valid}, 1);
      check("bp_data", bus.bus_data_out, 69);
      check("bp_ready", {31'd0, bus.rd_ready}, 0);
    end
    exp_q.push_back(32'd16);
    bus.bus_ack = 1'b1;
    #1;
    check("bp_ack_ready", {31'd0, bus.rd_ready}, 1);
    tick;
    bus.rd_req = 1'b0;
    check("bp_next_read", {31'd0, bus.bus_out_valid}, 0);
    check("bp_busy", {31'd0, bus.rd_ready}, 0);
    tick;
    check("bp_next_data", bus.bus_data_out, 16);
    tick;
    bus.bus_ack = 1'b0;
    regs[3] = 32'd69;

    // Back-to-back reads R0, R1, R3.
    exp_q.push_back(32'd16);
    exp_q.push_back(32'd18);
    exp_q.push_back(32'd69);
    vpat = 7'b0101010;
    bus.bus_ack = 1'b1;
    bus.rd_req = 1'b1;
    bus.rd_address = 4'd0;
    for (int c = 0; c < 7; c++) begin
      tick;
      if (c == 0) bus.rd_address = 4'd1;
      if (c == 2) bus.rd_address = 4'd3;
      if (c == 4) bus.rd_req = 1'b0;
      check("b2b_valid", {31'd0, bus.bus_out_valid},
            {31'd0, vpat[6-c]});
    end
    bus.bus_ack = 1'b0;
    tick;
    tick;
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_read_ctrl.md
Name: register_read_ctrl

Overview:
- Read-side companion to register_file. register_file takes writes (wr_enable / wr_address / bus_data_in) and exposes all registers in parallel; this block returns single-register reads.
- Accepts one read request at a time and selects the addressed register from the flattened register outputs.
- Places the value on the shared bus with a valid/ack handshake.
- Forwards a same-cycle write so a read never returns the pre-write value.

Parameters:
- DATA_WIDTH, 32, width of each register and of the bus.
- ADDR_WIDTH, 4, register address width.
- NUM_REGS, 16, register count; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous active-high reset, sampled on rising edge of clk.
- rd_req  input  1  read request; held until accepted.
- rd_address  input  ADDR_WIDTH  register to read; valid with rd_req.
- rd_ready  output  1  request accept; transfer occurs on an edge where rd_req && rd_ready.
- regs_in  input  NUM_REGS*DATA_WIDTH  register contents; Rn at bits [n*DATA_WIDTH +: DATA_WIDTH].
- wr_enable  input  1  register_file write strobe (snooped for forwarding).
- wr_address  input  ADDR_WIDTH  register_file write address (snooped).
- bus_data_in  input  DATA_WIDTH  register_file write data (snooped).
- bus_data_out  output  DATA_WIDTH  read data.
- bus_out_valid  output  1  bus_data_out holds a read result.
- bus_ack  input  1  consumer accepts bus_data_out on an edge where bus_out_valid && bus_ack.

Behaviour:
- States: IDLE, READ, HOLD. Reset state is IDLE.
- Reset (clr=1 at an edge):
  - state=IDLE, bus_data_out=0, bus_out_valid=0, captured address=0.
  - Any in-flight request or held data is dropped.
  - clr overrides every other input on the same edge.
- rd_ready is combinational and equals (state==IDLE) || (state==HOLD && bus_ack). It is 0 in READ and while clr=1.
- IDLE:
  - On an accepted request, capture rd_address and go to READ.
  - Otherwise stay in IDLE.
- READ (exactly one cycle):
  - On the next edge, bus_data_out <= (wr_enable && wr_address==captured) ? bus_data_in : regs_in[captured]. Then bus_out_valid <= 1 and go to HOLD.
  - Reason for the forward: register_file commits the write on the same edge, so regs_in still shows the old value during this cycle.
- HOLD:
  - bus_data_out and bus_out_valid stay stable until acknowledged.
  - Snapshot semantics: a later write to the held address does NOT update bus_data_out.
  - On an edge with bus_ack=1 and no accepted request: bus_out_valid <= 0, go to IDLE. bus_data_out keeps its last value.
  - On an edge with bus_ack=1 and rd_req=1 (back-to-back): capture the new address, bus_out_valid <= 0, go to READ.
  - On an edge with bus_ack=0: stay in HOLD.
- Latency: accept at edge k gives bus_out_valid=1 after edge k+1. Sustained throughput is one read per 2 cycles.
- bus_ack is ignored when bus_out_valid=0.
- rd_address is sampled only on the accept edge. Changing it afterwards has no effect.
- Out-of-range addresses cannot occur because NUM_REGS equals 2**ADDR_WIDTH.
- Writes to any address other than the one being read are ignored.

Test Plan:
- Reset mid-HOLD:
  - Stimulus: read R3 (=69), leave bus_ack=0, assert clr for 1 cycle.
  - Required: bus_out_valid=0 and bus_data_out=0 after the clr edge; rd_ready=1 the following cycle.
- Basic read:
  - Stimulus: after clr, preload regs_in R1=18; rd_req=1, rd_address=1 for one edge; bus_ack=1.
  - Required: bus_out_valid=1 and bus_data_out=18 exactly one edge after accept; valid drops on the next edge.
- Write forwarding:
  - Stimulus: R0=16; accept read of R0. During READ, drive wr_enable=1, wr_address=0, bus_data_in=26.
  - Required: bus_data_out=26, not 16.
- Non-matching write:
  - Stimulus: same as forwarding, but wr_address=2 with data 26.
  - Required: bus_data_out=16.
- Backpressure and snapshot:
  - Stimulus: read R3=69 with bus_ack=0 for 5 cycles; write R3=100 during HOLD; hold rd_req=1.
  - Required: bus_data_out stays 69 and valid stays 1; rd_ready=0 throughout; on bus_ack=1 the next read is accepted on that same edge.
- Back-to-back reads:
  - Stimulus: reads of R0, R1, R3 with bus_ack always 1 and rd_req always 1.
  - Required: valid pulses on alternate cycles carrying 16, 18, 69 in order, with no dropped request.
